// File: rtl/port_bank_pkg.sv
// Shared definitions for the port bank: register-bus address width,
// the register index enum and the individual register addresses.
package port_bank_pkg;

    localparam int ADDR_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        REG_OUT      = 3'd0,
        REG_DIR      = 3'd1,
        REG_IN       = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_RISE = 3'd4,
        REG_IRQ_FALL = 3'd5,
        REG_IRQ_STAT = 3'd6,
        REG_RSVD     = 3'd7
    } reg_idx_e;

    localparam logic [ADDR_W-1:0] ADDR_OUT  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IN   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 3'd6;

endpackage

// File: rtl/port_bank_if.sv
// Register bus between software-side logic and the port bank.
//   master: drives wr_en, rd_en, addr, wdata; receives rdata, rd_valid
//   slave : the port bank side
interface port_bank_if #(
    parameter int WIDTH = 8
);
    import port_bank_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              rd_valid;

    modport master (output wr_en, rd_en, addr, wdata, input  rdata, rd_valid);
    modport slave  (input  wr_en, rd_en, addr, wdata, output rdata, rd_valid);

endinterface

// File: rtl/port_sync.sv
// Multi-stage input synchroniser, reset to 0.
//   clk, rst : clock and synchronous active-high reset
//   i_d      : asynchronous pad values
//   o_q      : synchronised values, SYNC_STAGES edges after sampling
module port_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/port_bank_ctrl.sv
// Bank of WIDTH bidirectional pins with per-bit direction, output register,
// synchronised input path and sticky edge-detect interrupts.
//   clk, rst : clock and synchronous active-high reset
//   bus      : register bus (slave side), 8 registers, 1-cycle read latency
//   pins     : pad connections; bit i driven with OUT[i] when DIR[i]=1
//   irq      : level interrupt, OR of (IRQ_STAT & IRQ_EN)
module port_bank_ctrl
    import port_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    port_bank_if.slave       bus,
    inout  wire  [WIDTH-1:0] pins,
    output logic             irq
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_dir;
    logic [WIDTH-1:0]   r_irq_en;
    logic [WIDTH-1:0]   r_irq_rise;
    logic [WIDTH-1:0]   r_irq_fall;
    logic [WIDTH-1:0]   r_irq_stat;
    logic [WIDTH-1:0]   r_prev_in;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_rd_valid;
    logic [PRIME_W-1:0] r_prime_cnt;

    logic [WIDTH-1:0]   w_in;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_set;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_rd_mux;
    logic               w_primed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign pins[g] = r_dir[g] ? r_out[g] : 1'bz;
    end

    // Driven bits loop back through the synchroniser too.
    port_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pins),
        .o_q (w_in)
    );

    // The down-counter holds off edge detection until the synchroniser and
    // prev_in have both filled with real pin values, so pins already high
    // at reset release do not look like rising edges.
    always_comb begin
        w_primed = (r_prime_cnt == '0);
        w_rise   = w_in & ~r_prev_in;
        w_fall   = ~w_in & r_prev_in;
        w_set    = w_primed ? ((w_rise & r_irq_rise) | (w_fall & r_irq_fall)) : '0;
        w_clr    = (bus.wr_en && bus.addr == ADDR_STAT) ? bus.wdata : '0;
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_idx_e'(bus.addr))
            REG_OUT:      w_rd_mux = r_out;
            REG_DIR:      w_rd_mux = r_dir;
            REG_IN:       w_rd_mux = w_in;
            REG_IRQ_EN:   w_rd_mux = r_irq_en;
            REG_IRQ_RISE: w_rd_mux = r_irq_rise;
            REG_IRQ_FALL: w_rd_mux = r_irq_fall;
            REG_IRQ_STAT: w_rd_mux = r_irq_stat;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_dir       <= '0;
            r_irq_en    <= '0;
            r_irq_rise  <= '0;
            r_irq_fall  <= '0;
            r_irq_stat  <= '0;
            r_prev_in   <= '0;
            r_rdata     <= '0;
            r_rd_valid  <= 1'b0;
            r_prime_cnt <= PRIME_W'(SYNC_STAGES + 1);
        end else begin
            r_prev_in <= w_in;
            if (!w_primed) begin
                r_prime_cnt <= r_prime_cnt - PRIME_W'(1);
            end

            // Set is OR'd in after the clear so a same-cycle set wins.
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;

            if (bus.wr_en) begin
                case (bus.addr)
                    ADDR_OUT:  r_out      <= bus.wdata;
                    ADDR_DIR:  r_dir      <= bus.wdata;
                    ADDR_EN:   r_irq_en   <= bus.wdata;
                    ADDR_RISE: r_irq_rise <= bus.wdata;
                    ADDR_FALL: r_irq_fall <= bus.wdata;
                    ADDR_IN, ADDR_STAT: ;  // IN is read-only; STAT uses the W1C path
                    default: ;
                endcase
            end

            // Mux samples pre-write register values, so a same-cycle
            // read/write returns the old contents.
            r_rd_valid <= bus.rd_en;
            r_rdata    <= bus.rd_en ? w_rd_mux : '0;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign irq          = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_port_bank_ctrl.sv
module tb_port_bank_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq;
    logic [7:0] tb_val = 8'h00;
    logic [7:0] tb_oe  = 8'hFF;
    wire  [7:0] pins;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [7:0] m_out, m_dir, m_en, m_rise, m_fall, m_stat, m_prev;
    logic [7:0] m_samp[$];
    int         m_edges;
    logic       m_rvalid;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    port_bank_if #(.WIDTH(8)) bus();

    for (genvar g = 0; g < 8; g++) begin : g_tbpad
        assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
    end

    port_bank_ctrl #(.WIDTH(8), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .pins (pins),
        .irq  (irq)
    );

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_rise = '0; m_fall = '0;
        m_stat = '0; m_prev = '0; m_edges = 0; m_rvalid = 0; m_rdata = '0;
        m_samp.delete();
        repeat (S) m_samp.push_back(8'h00);
    endtask

    // Advance the model by one clock edge using the current inputs, then
    // let the DUT take the same edge.
    task automatic tick();
        logic [7:0] pin_now, in_now, rd, set, clr;
        pin_now = (m_dir & m_out) | (~m_dir & tb_val);
        in_now  = m_samp[S-1];
        if (rst) begin
            model_reset();
        end else begin
            case (bus.addr)
                3'd0: rd = m_out;
                3'd1: rd = m_dir;
                3'd2: rd = in_now;
                3'd3: rd = m_en;
                3'd4: rd = m_rise;
                3'd5: rd = m_fall;
                3'd6: rd = m_stat;
                default: rd = 8'h00;
            endcase
            m_rvalid = bus.rd_en;
            m_rdata  = bus.rd_en ? rd : 8'h00;
            set = (m_edges >= S + 1) ?
                  ((in_now & ~m_prev & m_rise) | (~in_now & m_prev & m_fall)) : 8'h00;
            clr = (bus.wr_en && bus.addr == 3'd6) ? bus.wdata : 8'h00;
            m_stat = (m_stat & ~clr) | set;
            if (bus.wr_en) begin
                case (bus.addr)
                    3'd0: m_out  = bus.wdata;
                    3'd1: m_dir  = bus.wdata;
                    3'd3: m_en   = bus.wdata;
                    3'd4: m_rise = bus.wdata;
                    3'd5: m_fall = bus.wdata;
                    default: ;
                endcase
            end
            m_prev = in_now;
            m_samp.push_front(pin_now);
            void'(m_samp.pop_back());
            m_edges++;
        end
        @(posedge clk);
        #1;
        tb_oe = ~m_dir;
        #1;
    endtask

    task automatic bus_idle();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 3'd0; bus.wdata = 8'h00;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [2:0] a);
        bus.rd_en = 1'b1; bus.addr = a;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        tb_val = 8'h00;
        repeat (3) tick();
        n_run++;
        if ({bus.rd_valid, bus.rdata, irq} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd_valid=%b rdata=%h irq=%b want 0 00 0",
                     bus.rd_valid, bus.rdata, irq);
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            n_run++;
            if ({bus.rd_valid, bus.rdata} !== 9'h100) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got valid=%b data=%h want 1 00",
                         a, bus.rd_valid, bus.rdata);
            end
        end
        n_run++;
        if (pins !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pins: got %h want 00", pins);
        end
    endtask

    task automatic test_drive();
        tb_val = 8'h30;
        wr(3'd0, 8'hA5);
        n_run++;
        if (pins !== 8'h30) begin
            n_fail++;
            $display("FAIL pins_undriven: got %h want 30", pins);
        end
        wr(3'd1, 8'h0F);
        n_run++;
        if (pins !== 8'h35) begin
            n_fail++;
            $display("FAIL pins_lower_driven: got %h want 35", pins);
        end
        tick();
        tick();
        rd(3'd2);
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== {1'b1, 8'h35}) begin
            n_fail++;
            $display("FAIL in_loopback: got valid=%b data=%h want 1 35", bus.rd_valid, bus.rdata);
        end
        wr(3'd1, 8'h00);
        repeat (4) tick();
    endtask

    task automatic test_edge_rise();
        tb_val = 8'h00;
        repeat (4) tick();
        wr(3'd4, 8'h10);
        wr(3'd3, 8'h10);
        tb_val[4] = 1'b1;
        tick();
        tick();
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early: got irq=%b want 0 at edge k+1", irq);
        end
        tick();
        n_run++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_irq: got irq=%b want 1 at edge k+2", irq);
        end
        rd(3'd6);
        n_run++;
        if ({bus.rd_valid, bus.rdata, irq} !== {1'b1, 8'h10, 1'b1}) begin
            n_fail++;
            $display("FAIL rise_stat: got valid=%b stat=%h irq=%b want 1 10 1",
                     bus.rd_valid, bus.rdata, irq);
        end
        wr(3'd6, 8'h10);
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq: got irq=%b want 0", irq);
        end
    endtask

    task automatic test_fall_masked();
        tb_val[0] = 1'b1;
        repeat (4) tick();
        wr(3'd5, 8'h01);
        wr(3'd3, 8'h00);
        tb_val[0] = 1'b0;
        repeat (3) tick();
        rd(3'd6);
        n_run++;
        if ({bus.rdata, irq} !== {8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL fall_masked: got stat=%h irq=%b want 01 0", bus.rdata, irq);
        end
        wr(3'd3, 8'h01);
        n_run++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_reenable: got irq=%b want 1", irq);
        end
        wr(3'd6, 8'h01);
        wr(3'd3, 8'h00);
    endtask

    task automatic test_collision();
        tb_val[4] = 1'b0;
        repeat (4) tick();
        wr(3'd6, 8'hFF);
        tb_val[4] = 1'b1;
        tick();
        tick();
        wr(3'd6, 8'h10);
        rd(3'd6);
        n_run++;
        if (bus.rdata !== 8'h10) begin
            n_fail++;
            $display("FAIL set_clear_collision: got stat=%h want 10", bus.rdata);
        end
        wr(3'd6, 8'h10);
        rd(3'd6);
        n_run++;
        if (bus.rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL w1c_plain: got stat=%h want 00", bus.rdata);
        end
    endtask

    task automatic test_read_hazard();
        wr(3'd0, 8'h11);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 3'd0; bus.wdata = 8'h3C;
        tick();
        bus_idle();
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== {1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL rd_wr_hazard: got valid=%b data=%h want 1 11", bus.rd_valid, bus.rdata);
        end
        rd(3'd0);
        n_run++;
        if (bus.rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL out_after_write: got %h want 3c", bus.rdata);
        end
        wr(3'd7, 8'hFF);
        rd(3'd7);
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL reserved_read: got valid=%b data=%h want 1 00", bus.rd_valid, bus.rdata);
        end
        bus.rd_en = 1'b1;
        bus.addr  = 3'd1;
        tick();
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL b2b_0: got valid=%b data=%h want 1 00", bus.rd_valid, bus.rdata);
        end
        bus.addr = 3'd0;
        tick();
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL b2b_1: got valid=%b data=%h want 1 3c", bus.rd_valid, bus.rdata);
        end
        bus_idle();
        tick();
        n_run++;
        if ({bus.rd_valid, bus.rdata} !== 9'h000) begin
            n_fail++;
            $display("FAIL rd_idle: got valid=%b data=%h want 0 00", bus.rd_valid, bus.rdata);
        end
    endtask

    task automatic test_random();
        logic [17:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) tb_val = 8'($urandom);
            bus.wr_en = ($urandom_range(0, 2) == 0);
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.addr  = 3'($urandom_range(0, 7));
            bus.wdata = 8'($urandom);
            tick();
            exp = {m_rvalid, m_rdata, |(m_stat & m_en), (m_dir & m_out) | (~m_dir & tb_val)};
            got = {bus.rd_valid, bus.rdata, irq, pins};
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got {valid,rdata,irq,pins}=%h want %h", i, got, exp);
            end
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        tb_val = 8'hFF;
        rst = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = 3'd0;
        tick();
        n_run++;
        if (bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drops_read: got rd_valid=%b want 0", bus.rd_valid);
        end
        tick();
        bus_idle();
        rst = 1'b0;
        wr(3'd4, 8'hFF);
        repeat (S + 1) tick();
        rd(3'd6);
        n_run++;
        if ({bus.rd_valid, bus.rdata, irq} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL prime_suppress: got valid=%b stat=%h irq=%b want 1 00 0",
                     bus.rd_valid, bus.rdata, irq);
        end
    endtask

    initial begin
        model_reset();
        bus_idle();
        test_reset();
        test_drive();
        test_edge_rise();
        test_fall_masked();
        test_collision();
        test_read_hazard();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
